dmem_responder: RTL and testbench

Data-memory responder for the pipeline's MEM stage: accepts the load/store request the stage issues (`mem_read`/`mem_write`/`addr`/`write_data`), performs RV32 byte/half/word accesses on an internal word-organised array, and returns `read_data` after a configurable number of wait states. It asserts `busy` so the hazard unit can freeze the pipeline, and flags misaligned or illegal accesses instead of performing them. It sits directly under the MEM stage in place of a zero-latency memory.

---
 rtl/dmem_responder_if.sv | 22 ++
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 tb/tb_dmem_responder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM-stage request/response bundle for dmem_responder
interface dmem_responder_if;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        busy;
   logic        mem_done;
   logic        misalign;

   modport master (
      output mem_read, mem_write, funct3, addr, write_data,
      input  read_data, busy, mem_done, misalign
   );

   modport slave (
      input  mem_read, mem_write, funct3, addr, write_data,
      output read_data, busy, mem_done, misalign
   );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated RV32 data memory with byte/half/word access and misalign rejection
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic           clk,
   input  logic           rst,
   dmem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

   state_t      state, next_state;
   logic [2:0]  cnt, next_cnt;
   logic        accept, reject;

   logic        op_store_q;
   logic [2:0]  f3_q;
   logic [AW+1:0] addr_q;
   logic [31:0] wdata_q;

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rd_q;
   logic        done_q, mis_q;

   logic        req, legal;
   logic        unused_addr_hi;

   assign req            = bus.mem_read | bus.mem_write;
   assign unused_addr_hi = ^bus.addr[31:AW+2];

   // mem_write takes priority, so a simultaneous read/write is judged as a store
   always_comb begin
      legal = 1'b1;
      if (bus.mem_write) begin
         if (bus.funct3[2] || bus.funct3[1:0] == 2'b11) legal = 1'b0;
      end else begin
         if (bus.funct3 == 3'b011 || bus.funct3[2:1] == 2'b11) legal = 1'b0;
      end
      if (bus.funct3[1:0] == 2'b01 && bus.addr[0]) legal = 1'b0;
      if (bus.funct3 == 3'b010 && bus.addr[1:0] != 2'b00) legal = 1'b0;
   end

   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      accept     = 1'b0;
      reject     = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (legal) begin
                  accept = 1'b1;
                  if (WAIT_STATES == 0) begin
                     next_state = ACCESS;
                  end else begin
                     next_state = WAIT;
                     next_cnt   = 3'(WAIT_STATES);
                  end
               end else begin
                  reject = 1'b1;
               end
            end
         end
         WAIT: begin
            if (cnt <= 3'd1) next_state = ACCESS;
            else             next_cnt   = cnt - 3'd1;
         end
         ACCESS:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && req) begin
         op_store_q <= bus.mem_write;
         f3_q       <= bus.funct3;
         addr_q     <= bus.addr[AW+1:0];
         wdata_q    <= bus.write_data;
      end
   end

   logic [AW-1:0] idx;
   logic [31:0]   word;
   logic [7:0]    lane_byte;
   logic [15:0]   lane_half;
   logic [31:0]   load_val;
   logic [3:0]    be;
   logic [31:0]   st_data;

   assign idx  = addr_q[AW+1:2];
   assign word = mem[idx];

   always_comb begin
      lane_byte = word[8*addr_q[1:0] +: 8];
      lane_half = addr_q[1] ? word[31:16] : word[15:0];
      case (f3_q)
         3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
         3'b100:  load_val = {24'd0, lane_byte};
         3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
         3'b101:  load_val = {16'd0, lane_half};
         default: load_val = word;
      endcase
   end

   // store data is replicated across lanes; the byte enables pick the real target
   always_comb begin
      case (f3_q[1:0])
         2'b00: begin
            be      = 4'b0001 << addr_q[1:0];
            st_data = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be      = addr_q[1] ? 4'b1100 : 4'b0011;
            st_data = {2{wdata_q[15:0]}};
         end
         default: begin
            be      = 4'b1111;
            st_data = wdata_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst && state == ACCESS && op_store_q) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done_q <= 1'b0;
         mis_q  <= 1'b0;
         rd_q   <= 32'd0;
      end else begin
         done_q <= 1'b0;
         mis_q  <= 1'b0;
         if (reject) begin
            done_q <= 1'b1;
            mis_q  <= 1'b1;
            rd_q   <= 32'd0;
         end else if (state == ACCESS) begin
            done_q <= 1'b1;
            if (!op_store_q) rd_q <= load_val;
         end
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.mem_done  = done_q;
   assign bus.misalign  = mis_q;
   assign bus.read_data = rd_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder with a byte-array reference model
module tb_dmem_responder;
   localparam int DEPTH = 64;
   localparam int WS    = 3;
   localparam int BYTES = DEPTH * 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dmem_responder_if bus ();

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] rd;
      logic        mis;
      int          busy_n;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          mon_busy_run = 0;
   int          checks = 0;
   int          failures = 0;
   logic [7:0]  ref_mem [BYTES];
   logic [31:0] last_rd = 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   function automatic int access_size(input logic [2:0] f);
      case (f)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010:         return 4;
         default:        return 0;
      endcase
   endfunction

   function automatic bit is_legal(input bit st, input logic [2:0] f, input logic [31:0] a);
      int size;
      size = access_size(f);
      if (size == 0) return 1'b0;
      if (st && f[2]) return 1'b0;
      return (a % 32'(size)) == 32'd0;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a);
      int unsigned b;
      int          size;
      logic [31:0] v;
      b    = a % 32'(BYTES);
      size = access_size(f);
      v    = 32'd0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_mem[b + i]) << (8 * i));
      if (!f[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
      return v;
   endfunction

   task automatic model_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
      int unsigned b;
      b = a % 32'(BYTES);
      for (int i = 0; i < access_size(f); i++) ref_mem[b + i] = wd[8*i +: 8];
   endtask

   // called #1 after a rising edge with the DUT idle
   task automatic issue(input bit rd, input bit wr, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd);
      exp_t e;
      int   n;
      if (is_legal(wr, f, a)) begin
         if (wr) model_store(f, a, wd);
         else    last_rd = model_load(f, a);
         e.rd = last_rd; e.mis = 1'b0; e.busy_n = WS + 1;
      end else begin
         last_rd = 32'd0;
         e.rd = 32'd0; e.mis = 1'b1; e.busy_n = 0;
      end
      sb.push_back(e);
      bus.mem_read = rd; bus.mem_write = wr; bus.funct3 = f;
      bus.addr = a; bus.write_data = wd;
      @(posedge clk); #1;
      bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      n = 0;
      while (bus.busy && n < 50) begin
         bus.mem_read   = 1'($urandom);
         bus.mem_write  = 1'($urandom);
         bus.funct3     = 3'($urandom);
         bus.addr       = $urandom;
         bus.write_data = $urandom;
         @(posedge clk); #1;
         n++;
      end
      bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      if (bus.busy) check("busy_timeout", 32'd1, 32'd0);
   endtask

   task automatic reset_abort(input logic [31:0] a, input logic [31:0] wd);
      bus.mem_read = 1'b0; bus.mem_write = 1'b1; bus.funct3 = 3'b010;
      bus.addr = a; bus.write_data = wd;
      @(posedge clk); #1;
      bus.mem_write = 1'b0;
      @(posedge clk); #1;
      check("abort_in_wait", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      last_rd = 32'd0;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.mem_done), 32'd0);
      check("abort_misalign", 32'(bus.misalign), 32'd0);
      check("abort_read_data", bus.read_data, 32'd0);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_busy_run = 0;
         end else begin
            if (bus.busy) mon_busy_run++;
            if (bus.misalign && !bus.mem_done) check("misalign_without_done", 32'd1, 32'd0);
            if (bus.mem_done) begin
               if (sb.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  mon_e = sb.pop_front();
                  check("read_data", bus.read_data, mon_e.rd);
                  check("misalign", 32'(bus.misalign), 32'(mon_e.mis));
                  check("busy_cycles", 32'(mon_busy_run), 32'(mon_e.busy_n));
               end
               mon_busy_run = 0;
            end
         end
      end
   end

   initial begin
      logic [2:0]  f;
      logic [31:0] a;
      int          size;
      bit          wr;
      bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.funct3 = 3'b000;
      bus.addr = 32'd0; bus.write_data = 32'd0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.mem_done), 32'd0);
      check("reset_misalign", 32'(bus.misalign), 32'd0);
      check("reset_read_data", bus.read_data, 32'd0);
      rst = 1'b0;

      for (int w = 0; w < DEPTH; w++) issue(1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom);

      issue(0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
      issue(1, 0, 3'b010, 32'h10, 32'h0);
      issue(0, 1, 3'b000, 32'h13, 32'h00000080);
      issue(1, 0, 3'b000, 32'h13, 32'h0);
      issue(1, 0, 3'b100, 32'h13, 32'h0);
      issue(1, 0, 3'b010, 32'h10, 32'h0);
      issue(0, 1, 3'b001, 32'h22, 32'h00008001);
      issue(1, 0, 3'b001, 32'h22, 32'h0);
      issue(1, 0, 3'b101, 32'h22, 32'h0);
      issue(1, 0, 3'b010, 32'h20, 32'h0);
      issue(1, 0, 3'b010, 32'h102, 32'h0);
      issue(0, 1, 3'b001, 32'h101, 32'hFFFFFFFF);
      issue(1, 0, 3'b011, 32'h100, 32'h0);
      issue(0, 1, 3'b100, 32'h104, 32'hFFFFFFFF);
      issue(1, 0, 3'b010, 32'h100, 32'h0);
      issue(1, 0, 3'b010, 32'h104, 32'h0);
      issue(1, 1, 3'b010, 32'h0, 32'h12345678);
      issue(1, 0, 3'b010, 32'h0, 32'h0);
      issue(1, 0, 3'b010, 32'(4 * DEPTH), 32'h0);

      reset_abort(32'h40, 32'hAAAA5555);
      issue(1, 0, 3'b010, 32'h40, 32'h0);

      for (int k = 0; k < 300; k++) begin
         f    = 3'($urandom);
         wr   = 1'($urandom);
         a    = $urandom;
         size = access_size(f);
         if ($urandom_range(0, 3) != 0 && size != 0) a = a & ~(32'(size) - 32'd1);
         issue(wr ? 1'($urandom) : 1'b1, wr, f, a, $urandom);
      end

      for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
